// File: rtl/bus_pkg.sv
// Shared types, constants and helpers for the per-device bus FIFO pair.
package bus_pkg;

    localparam int unsigned PCKG_SZ = 16;
    localparam logic [7:0]  BC_ID   = 8'hFF;

    typedef logic [PCKG_SZ-1:0] pkt_t;

    // MSB index of the 8-bit destination field for a packet of width w.
    function automatic int unsigned id_msb(int unsigned w);
        return w - 1;
    endfunction

    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted when a read frees a slot.
module sync_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [width-1:0]       wdata,
    input  logic                   rd,
    output logic [width-1:0]       rdata,
    output logic [$clog2(depth):0] cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rd_ok, wr_ok;

    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CW'(depth));
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd_ok);
        ovf   = wr & ~wr_ok;
        cnt_d = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device TX/RX FIFO pair with destination filtering and saturating event counters.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz = PCKG_SZ,
    parameter int unsigned depth   = 8,
    parameter logic [7:0]  drv_id  = 8'd0,
    parameter logic [7:0]  bc      = BC_ID
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_wr,
    input  logic [pckg_sz-1:0]     tx_data,
    output logic                   tx_full,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    output logic                   rx_valid,
    output logic [pckg_sz-1:0]     rx_data,
    input  logic                   rx_rd,
    output logic [$clog2(depth):0] tx_cnt,
    output logic [$clog2(depth):0] rx_cnt,
    output logic [7:0]             tx_ovf,
    output logic [7:0]             rx_ovf,
    output logic [7:0]             rx_drop
);

    localparam int unsigned IdMsb = id_msb(pckg_sz);

    logic       tx_empty, tx_ovf_ev;
    logic       rx_empty, rx_ovf_ev, rx_full_unused;
    logic [7:0] dest;
    logic       match, rx_wr, drop_ev;
    logic [7:0] tx_ovf_q, rx_ovf_q, rx_drop_q;

    assign dest    = D_push[IdMsb -: 8];
    assign match   = (dest == drv_id) || (dest == bc);
    assign rx_wr   = push & match;
    assign drop_ev = push & ~match;

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .cnt   (tx_cnt),
        .full  (tx_full),
        .empty (tx_empty),
        .ovf   (tx_ovf_ev)
    );

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .cnt   (rx_cnt),
        .full  (rx_full_unused),
        .empty (rx_empty),
        .ovf   (rx_ovf_ev)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_q  <= '0;
            rx_ovf_q  <= '0;
            rx_drop_q <= '0;
        end else begin
            if (tx_ovf_ev) tx_ovf_q  <= sat_inc(tx_ovf_q);
            if (rx_ovf_ev) rx_ovf_q  <= sat_inc(rx_ovf_q);
            if (drop_ev)   rx_drop_q <= sat_inc(rx_drop_q);
        end
    end

    assign pndng    = ~tx_empty;
    assign rx_valid = ~rx_empty;
    assign tx_ovf   = tx_ovf_q;
    assign rx_ovf   = rx_ovf_q;
    assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed plus randomized bench for bus_dev_fifo against a queue-based reference model.
module tb_bus_dev_fifo;

    localparam int         PW    = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'h02;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_wr = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
    logic [PW-1:0] tx_data = '0, D_push = '0;
    logic          tx_full, pndng, rx_valid;
    logic [PW-1:0] D_pop, rx_data;
    logic [3:0]    tx_cnt, rx_cnt;
    logic [7:0]    tx_ovf, rx_ovf, rx_drop;

    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    int            txovf_n = 0, rxovf_n = 0, drop_n = 0;
    int            n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    bus_dev_fifo #(
        .pckg_sz (PW),
        .depth   (DEPTH),
        .drv_id  (ID),
        .bc      (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .tx_cnt   (tx_cnt),
        .rx_cnt   (rx_cnt),
        .tx_ovf   (tx_ovf),
        .rx_ovf   (rx_ovf),
        .rx_drop  (rx_drop)
    );

    function automatic int sat(int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ":pndng"},    32'(pndng),    32'(txq.size() > 0));
        chk({tag, ":tx_full"},  32'(tx_full),  32'(txq.size() == DEPTH));
        chk({tag, ":tx_cnt"},   32'(tx_cnt),   32'(txq.size()));
        if (txq.size() > 0) chk({tag, ":D_pop"}, 32'(D_pop), 32'(txq[0]));
        chk({tag, ":rx_valid"}, 32'(rx_valid), 32'(rxq.size() > 0));
        chk({tag, ":rx_cnt"},   32'(rx_cnt),   32'(rxq.size()));
        if (rxq.size() > 0) chk({tag, ":rx_data"}, 32'(rx_data), 32'(rxq[0]));
        chk({tag, ":tx_ovf"},   32'(tx_ovf),   32'(sat(txovf_n)));
        chk({tag, ":rx_ovf"},   32'(rx_ovf),   32'(sat(rxovf_n)));
        chk({tag, ":rx_drop"},  32'(rx_drop),  32'(sat(drop_n)));
    endtask

    // One clock of stimulus; the model is advanced from the rules, then all outputs are compared.
    task automatic step(string tag, logic wr, logic [PW-1:0] wd, logic p,
                        logic ps, logic [PW-1:0] dp, logic rd);
        bit tx_pop_ok, rx_rd_ok, hit;
        tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = dp; rx_rd = rd;
        tx_pop_ok = p && (txq.size() > 0);
        if (tx_pop_ok) void'(txq.pop_front());
        if (wr) begin
            if (txq.size() < DEPTH) txq.push_back(wd);
            else txovf_n++;
        end
        rx_rd_ok = rd && (rxq.size() > 0);
        if (rx_rd_ok) void'(rxq.pop_front());
        hit = (dp[PW-1 -: 8] == ID) || (dp[PW-1 -: 8] == 8'hFF);
        if (ps) begin
            if (!hit) drop_n++;
            else if (rxq.size() < DEPTH) rxq.push_back(dp);
            else rxovf_n++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    endtask

    task automatic model_clear();
        txq.delete(); rxq.delete();
        txovf_n = 0; rxovf_n = 0; drop_n = 0;
    endtask

    initial begin
        logic [PW-1:0] d;
        // Reset and idle
        repeat (5) @(posedge clk);
        #1;
        chk("rst:pndng", 32'(pndng), 0);
        chk("rst:rx_valid", 32'(rx_valid), 0);
        reset = 1'b1;
        check_all("idle");
        chk("idle:D_pop", 32'(D_pop), 0);
        chk("idle:rx_data", 32'(rx_data), 0);
        for (int i = 0; i < 3; i++) step("idle_pop", 0, '0, 1, 0, '0, 1);
        chk("idle_pop:D_pop", 32'(D_pop), 0);

        // TX fill, overflow, drain
        for (int i = 0; i < 8; i++) step("fill", 1, 16'h0100 + 16'(i), 0, 0, '0, 0);
        chk("fill:tx_full", 32'(tx_full), 1);
        chk("fill:tx_cnt", 32'(tx_cnt), 8);
        step("ovf", 1, 16'h0108, 0, 0, '0, 0);
        chk("ovf:tx_ovf", 32'(tx_ovf), 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain:D_pop", 32'(D_pop), 32'(16'h0100 + 16'(i)));
            step("drain", 0, '0, 1, 0, '0, 0);
        end
        chk("drain:pndng", 32'(pndng), 0);

        // Simultaneous write+pop when full, then when empty
        for (int i = 0; i < 8; i++) step("refill", 1, 16'h0200 + 16'(i), 0, 0, '0, 0);
        step("full_wp", 1, 16'h0AAA, 1, 0, '0, 0);
        chk("full_wp:tx_cnt", 32'(tx_cnt), 8);
        for (int i = 0; i < 7; i++) step("drain2", 0, '0, 1, 0, '0, 0);
        chk("full_wp:last", 32'(D_pop), 32'h0AAA);
        step("drain2", 0, '0, 1, 0, '0, 0);
        step("empty_wp", 1, 16'h0555, 1, 0, '0, 0);
        chk("empty_wp:tx_cnt", 32'(tx_cnt), 1);
        chk("empty_wp:D_pop", 32'(D_pop), 32'h0555);
        step("empty_wp_drain", 0, '0, 1, 0, '0, 0);

        // RX filter
        step("rx_own", 0, '0, 0, 1, 16'h0211, 0);
        step("rx_bc", 0, '0, 0, 1, 16'hFF22, 0);
        step("rx_other", 0, '0, 0, 1, 16'h0333, 0);
        chk("rx_other:rx_drop", 32'(rx_drop), 1);
        chk("rx_rd0", 32'(rx_data), 32'h0211);
        step("rx_rd", 0, '0, 0, 0, '0, 1);
        chk("rx_rd1", 32'(rx_data), 32'hFF22);
        step("rx_rd", 0, '0, 0, 0, '0, 1);

        // RX overflow and push+read while full
        for (int i = 0; i < 9; i++) step("rx_fill", 0, '0, 0, 1, 16'h0240 + 16'(i), 0);
        chk("rx_fill:rx_ovf", 32'(rx_ovf), 1);
        step("rx_full_pr", 0, '0, 0, 1, 16'h02EE, 1);
        chk("rx_full_pr:rx_cnt", 32'(rx_cnt), 8);
        for (int i = 0; i < 8; i++) step("rx_drain", 0, '0, 0, 0, '0, 1);

        // Continuous streaming across pointer wrap on both sides
        step("stream0", 1, 16'h1000, 0, 1, 16'h0200, 0);
        for (int i = 1; i <= 40; i++) begin
            step("stream", 1, 16'h1000 + 16'(i), 1, 1, {ID, 8'(i)}, 1);
        end
        chk("stream:tx_cnt", 32'(tx_cnt), 1);
        chk("stream:D_pop", 32'(D_pop), 32'h1028);
        step("stream_end", 0, '0, 1, 0, '0, 1);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) step("drop_sat", 0, '0, 0, 1, 16'h0500 + 16'(i % 256), 0);
        chk("drop_sat:rx_drop", 32'(rx_drop), 255);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [7:0]  dst;
            r = $urandom_range(0, 3);
            dst = (r == 0) ? ID : (r == 1) ? 8'hFF : 8'($urandom);
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), {dst, 8'($urandom)}, 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-stream
        while (txq.size() > 0) step("pre_rst", 0, '0, 1, 0, '0, 1);
        for (int i = 0; i < 5; i++) step("pre_rst_fill", 1, 16'h0300 + 16'(i), 0, 0, '0, 0);
        chk("pre_rst:tx_cnt", 32'(tx_cnt), 5);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst:pndng", 32'(pndng), 0);
        chk("mid_rst:tx_cnt", 32'(tx_cnt), 0);
        model_clear();
        @(posedge clk);
        #1;
        check_all("mid_rst_hold");
        chk("mid_rst_hold:D_pop", 32'(D_pop), 0);
        #2 reset = 1'b1;
        d = 16'h0ABC;
        step("post_rst", 1, d, 0, 0, '0, 0);
        chk("post_rst:D_pop", 32'(D_pop), 32'(d));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
